// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the 800x600 @ 40 MHz pipeline.
package vga_pkg;

  // Visible area and total frame size for the 800x600 @ 60 Hz mode.
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int HOR_TOTAL  = 1056;
  localparam int VER_TOTAL  = 628;

  // Falling sprite geometry and its transparent colour.
  localparam int          RECT_WIDTH     = 48;
  localparam int          RECT_HEIGHT    = 64;
  localparam logic [11:0] RECT_KEY_COLOR = 12'h0F0;

  // Everything that travels alongside a pixel in the timing bus.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_timing_t;

  // Widen a 12-bit coordinate to 13 bits so that adding the sprite size
  // to a position near 4095 cannot wrap back into the visible range.
  function automatic logic [12:0] ext13(input logic [11:0] val);
    return {1'b0, val};
  endfunction

endpackage

// File: rtl/delay.sv
// Generic shift-register delay line with synchronous active-high reset.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] del_q [CLK_DEL];

  // Shift the input through CLK_DEL registers; reset clears every stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CLK_DEL; i++) begin
        del_q[i] <= '0;
      end
    end else begin
      del_q[0] <= din_i;
      for (int i = 1; i < CLK_DEL; i++) begin
        del_q[i] <= del_q[i-1];
      end
    end
  end

  assign dout_o = del_q[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_pic.sv
// Composites a keyed sprite from an external synchronous ROM onto the
// background VGA stream. Two-stage pipeline; position latched per frame.
module draw_rect_pic
  import vga_pkg::*;
#(
  parameter int          RECT_W    = RECT_WIDTH,
  parameter int          RECT_H    = RECT_HEIGHT,
  parameter logic [11:0] KEY_COLOR = RECT_KEY_COLOR
) (
  input  logic        clk40MHz,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] rgb_pixel,
  output logic [11:0] pixel_addr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // ---------------------------------------------------------------------
  // Frame-start position latch
  // ---------------------------------------------------------------------
  logic        frame_start;
  logic [11:0] xpos_l_q, xpos_l_d;
  logic [11:0] ypos_l_q, ypos_l_d;

  assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

  // Load a new position only at (0,0); the loaded value is also used for
  // that very pixel so the whole frame sees one consistent position.
  always_comb begin
    xpos_l_d = xpos_l_q;
    ypos_l_d = ypos_l_q;
    if (frame_start) begin
      xpos_l_d = xpos;
      ypos_l_d = ypos;
    end
  end

  // Position registers.
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      xpos_l_q <= 12'd0;
      ypos_l_q <= 12'd0;
    end else begin
      xpos_l_q <= xpos_l_d;
      ypos_l_q <= ypos_l_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: hit test and ROM address
  // ---------------------------------------------------------------------
  logic [12:0] h13, v13, x13, y13;
  logic [12:0] x_end13, y_end13;
  logic        in_rect;
  logic [5:0]  col6, row6;
  logic [11:0] pixel_addr_q, pixel_addr_d;

  assign h13     = {2'b00, hcount_in};
  assign v13     = {2'b00, vcount_in};
  assign x13     = ext13(xpos_l_d);
  assign y13     = ext13(ypos_l_d);
  assign x_end13 = x13 + 13'(RECT_W);
  assign y_end13 = y13 + 13'(RECT_H);

  // Rectangle hit test at 13-bit width so large positions never wrap.
  always_comb begin
    in_rect = (h13 >= x13) && (h13 < x_end13) &&
              (v13 >= y13) && (v13 < y_end13);
  end

  // The low six bits of a difference depend only on the low six bits of
  // the operands, so the ROM offsets are computed at 6-bit width.
  always_comb begin
    col6         = hcount_in[5:0] - xpos_l_d[5:0];
    row6         = vcount_in[5:0] - ypos_l_d[5:0];
    pixel_addr_d = in_rect ? {row6, col6} : 12'd0;
  end

  // ROM address register; the ROM answers before the stage-2 edge.
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      pixel_addr_q <= 12'd0;
    end else begin
      pixel_addr_q <= pixel_addr_d;
    end
  end

  assign pixel_addr = pixel_addr_q;

  // ---------------------------------------------------------------------
  // Side-band delay lines
  // ---------------------------------------------------------------------
  vga_timing_t timing_in_s;
  vga_timing_t timing_out_s;
  logic [$bits(vga_timing_t)-1:0] timing_out_v;

  assign timing_in_s = '{hcount: hcount_in, vcount: vcount_in,
                         hsync: hsync_in, vsync: vsync_in,
                         hblnk: hblnk_in, vblnk: vblnk_in};

  // Timing bus travels both stages so it lines up with rgb_out.
  delay #(
    .WIDTH   ($bits(vga_timing_t)),
    .CLK_DEL (2)
  ) u_timing_delay (
    .clk_i  (clk40MHz),
    .rst_i  (rst),
    .din_i  (timing_in_s),
    .dout_o (timing_out_v)
  );

  assign timing_out_s = vga_timing_t'(timing_out_v);

  // Background pixel, hit flag and blanking strobes needed by stage 2.
  // The blanking bits ride here because stage 2 needs them after one
  // stage, while the timing bus only exposes its two-stage output.
  logic [14:0] aux_in, aux_d1;
  logic [11:0] rgb_in_d1;
  logic        in_rect_d1;
  logic        hblnk_d1, vblnk_d1;

  assign aux_in = {rgb_in, in_rect, hblnk_in, vblnk_in};

  delay #(
    .WIDTH   (15),
    .CLK_DEL (1)
  ) u_aux_delay (
    .clk_i  (clk40MHz),
    .rst_i  (rst),
    .din_i  (aux_in),
    .dout_o (aux_d1)
  );

  assign {rgb_in_d1, in_rect_d1, hblnk_d1, vblnk_d1} = aux_d1;

  // ---------------------------------------------------------------------
  // Stage 2: compositing
  // ---------------------------------------------------------------------
  logic [11:0] rgb_out_q, rgb_out_d;

  // Blanking wins, then an opaque sprite pixel, then the background.
  always_comb begin
    rgb_out_d = rgb_in_d1;
    if (hblnk_d1 || vblnk_d1) begin
      rgb_out_d = 12'h000;
    end else if (in_rect_d1 && (rgb_pixel != KEY_COLOR)) begin
      rgb_out_d = rgb_pixel;
    end
  end

  // Output colour register.
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      rgb_out_q <= 12'h000;
    end else begin
      rgb_out_q <= rgb_out_d;
    end
  end

  assign rgb_out    = rgb_out_q;
  assign hcount_out = timing_out_s.hcount;
  assign vcount_out = timing_out_s.vcount;
  assign hsync_out  = timing_out_s.hsync;
  assign vsync_out  = timing_out_s.vsync;
  assign hblnk_out  = timing_out_s.hblnk;
  assign vblnk_out  = timing_out_s.vblnk;

endmodule

// File: tb/tb_draw_rect_pic.sv
// Directed bench for draw_rect_pic with a behavioural sprite ROM.
module tb_draw_rect_pic;
  import vga_pkg::*;

  localparam logic [11:0] SPR = 12'hF00;
  localparam logic [11:0] BG  = 12'h00F;

  // ------------------------------------------------------------ clock/reset
  logic clk40MHz = 1'b0;
  logic rst;
  always #5 clk40MHz = ~clk40MHz;

  logic [11:0] xpos, ypos;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, rgb_pixel, pixel_addr;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int num_checks = 0;
  int num_errors = 0;
  int rom_mode   = 0;
  logic [11:0] bg_rgb = BG;
  logic [22:0] exp_q[$];

  draw_rect_pic dut (
    .clk40MHz   (clk40MHz),
    .rst        (rst),
    .xpos       (xpos),
    .ypos       (ypos),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .rgb_pixel  (rgb_pixel),
    .pixel_addr (pixel_addr),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  // ROM model: data for the registered address is ready before the next edge.
  // Mode 0: solid sprite colour. Mode 1: column 0 is the key colour.
  always_comb begin
    rgb_pixel = SPR;
    if (rom_mode == 1 && pixel_addr[5:0] == 6'd0) rgb_pixel = RECT_KEY_COLOR;
  end

  // Expected timing bus for a counter pair {h, v, hs, vs, hb, vb}.
  function automatic logic [25:0] exp_timing(input logic [10:0] h, input logic [10:0] v);
    return {h, v, (h >= 11'd840 && h < 11'd968), (v >= 11'd601 && v < 11'd605),
            (h >= 11'd800), (v >= 11'd600)};
  endfunction

  function automatic logic [25:0] act_timing();
    return {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out};
  endfunction

  // ------------------------------------------------------------ drivers
  task automatic set_inputs(input logic [10:0] h, input logic [10:0] v);
    logic [25:0] t;
    t = exp_timing(h, v);
    hcount_in = h;
    vcount_in = v;
    hsync_in  = t[3];
    vsync_in  = t[2];
    hblnk_in  = t[1];
    vblnk_in  = t[0];
    rgb_in    = bg_rgb;
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v);
    @(negedge clk40MHz);
    set_inputs(h, v);
  endtask

  // Present a frame start with a new position, then step off (0,0).
  task automatic set_frame(input logic [11:0] x, input logic [11:0] y);
    @(negedge clk40MHz);
    xpos = x;
    ypos = y;
    set_inputs(11'd0, 11'd0);
    drive(11'd1, 11'd1);
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    rst    = 1'b1;
    xpos   = 12'd100;
    ypos   = 12'd200;
    bg_rgb = 12'hABC;
    set_inputs(11'd500, 11'd300);
    repeat (3) @(negedge clk40MHz);
    num_checks++;
    if (rgb_out !== 12'h000) begin
      num_errors++;
      $display("FAIL reset_rgb: got %h expected 000", rgb_out);
    end
    num_checks++;
    if (pixel_addr !== 12'h000) begin
      num_errors++;
      $display("FAIL reset_addr: got %h expected 000", pixel_addr);
    end
    num_checks++;
    if (act_timing() !== 26'd0) begin
      num_errors++;
      $display("FAIL reset_timing: got %h expected 0", act_timing());
    end
    @(negedge clk40MHz);
    rst    = 1'b0;
    bg_rgb = BG;
  endtask

  task automatic test_basic();
    logic [10:0] hs [8] = '{11'd100, 11'd147, 11'd100, 11'd147, 11'd99, 11'd148, 11'd100, 11'd100};
    logic [10:0] vs [8] = '{11'd200, 11'd200, 11'd263, 11'd263, 11'd200, 11'd200, 11'd199, 11'd264};
    logic [11:0] es [8] = '{SPR, SPR, SPR, SPR, BG, BG, BG, BG};
    rom_mode = 0;
    set_frame(12'd100, 12'd200);
    for (int i = 0; i < 8; i++) begin
      drive(hs[i], vs[i]);
      repeat (2) @(negedge clk40MHz);
      num_checks++;
      if (rgb_out !== es[i]) begin
        num_errors++;
        $display("FAIL basic_rgb(%0d,%0d): got %h expected %h", hs[i], vs[i], rgb_out, es[i]);
      end
      num_checks++;
      if (act_timing() !== exp_timing(hs[i], vs[i])) begin
        num_errors++;
        $display("FAIL basic_timing(%0d,%0d): got %h expected %h", hs[i], vs[i],
                 act_timing(), exp_timing(hs[i], vs[i]));
      end
    end
  endtask

  task automatic test_latency();
    drive(11'd99, 11'd210);
    repeat (2) @(negedge clk40MHz);
    drive(11'd120, 11'd210);
    @(negedge clk40MHz);
    num_checks++;
    if (rgb_out !== BG || hcount_out !== 11'd99) begin
      num_errors++;
      $display("FAIL latency_1cyc: got rgb %h h %0d expected %h h 99", rgb_out, hcount_out, BG);
    end
    @(negedge clk40MHz);
    num_checks++;
    if (rgb_out !== SPR || hcount_out !== 11'd120) begin
      num_errors++;
      $display("FAIL latency_2cyc: got rgb %h h %0d expected %h h 120", rgb_out, hcount_out, SPR);
    end
  endtask

  task automatic test_address();
    logic [10:0] hs [3] = '{11'd105, 11'd147, 11'd148};
    logic [10:0] vs [3] = '{11'd203, 11'd263, 11'd263};
    logic [11:0] es [3] = '{12'h0C5, 12'hFEF, 12'h000};
    for (int i = 0; i < 3; i++) begin
      drive(hs[i], vs[i]);
      @(negedge clk40MHz);
      num_checks++;
      if (pixel_addr !== es[i]) begin
        num_errors++;
        $display("FAIL addr(%0d,%0d): got %h expected %h", hs[i], vs[i], pixel_addr, es[i]);
      end
    end
  endtask

  task automatic test_transparency();
    logic [10:0] hs [3] = '{11'd100, 11'd101, 11'd100};
    logic [11:0] bs [3] = '{BG, BG, 12'h123};
    logic [11:0] es [3] = '{BG, SPR, 12'h123};
    rom_mode = 1;
    for (int i = 0; i < 3; i++) begin
      bg_rgb = bs[i];
      drive(hs[i], 11'd210);
      repeat (2) @(negedge clk40MHz);
      num_checks++;
      if (rgb_out !== es[i]) begin
        num_errors++;
        $display("FAIL transparency(%0d): got %h expected %h", hs[i], rgb_out, es[i]);
      end
    end
    rom_mode = 0;
    bg_rgb   = BG;
  endtask

  task automatic test_frame_start_same_cycle();
    set_frame(12'd300, 12'd300);
    @(negedge clk40MHz);
    xpos = 12'd0;
    ypos = 12'd0;
    set_inputs(11'd0, 11'd0);
    repeat (2) @(negedge clk40MHz);
    num_checks++;
    if (rgb_out !== SPR) begin
      num_errors++;
      $display("FAIL same_cycle_latch: got %h expected %h", rgb_out, SPR);
    end
  endtask

  task automatic test_tearing();
    logic [10:0] hs [6] = '{11'd100, 11'd300, 11'd120, 11'd100, 11'd300, 11'd347};
    logic [10:0] vs [6] = '{11'd300, 11'd300, 11'd353, 11'd300, 11'd300, 11'd300};
    logic [11:0] es [6] = '{SPR, BG, SPR, BG, SPR, SPR};
    set_frame(12'd100, 12'd290);
    xpos = 12'd300;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) set_frame(12'd300, 12'd290);
      drive(hs[i], vs[i]);
      repeat (2) @(negedge clk40MHz);
      num_checks++;
      if (rgb_out !== es[i]) begin
        num_errors++;
        $display("FAIL tearing_%0d(%0d,%0d): got %h expected %h", i, hs[i], vs[i], rgb_out, es[i]);
      end
    end
  endtask

  task automatic test_clipping();
    logic [11:0] xs [11] = '{12'd780, 12'd780, 12'd780, 12'd780, 12'd780,
                             12'd4090, 12'd4090, 12'd4090, 12'd4090, 12'd100, 12'd100};
    logic [11:0] ys [11] = '{12'd200, 12'd200, 12'd200, 12'd200, 12'd200,
                             12'd200, 12'd200, 12'd200, 12'd200, 12'd580, 12'd580};
    logic [10:0] hs [11] = '{11'd780, 11'd799, 11'd779, 11'd800, 11'd827,
                             11'd0, 11'd20, 11'd41, 11'd42, 11'd120, 11'd120};
    logic [10:0] vs [11] = '{11'd210, 11'd210, 11'd210, 11'd210, 11'd210,
                             11'd210, 11'd210, 11'd210, 11'd210, 11'd599, 11'd600};
    logic [11:0] es [11] = '{SPR, SPR, BG, 12'h000, 12'h000,
                             BG, BG, BG, BG, SPR, 12'h000};
    for (int i = 0; i < 11; i++) begin
      if (i == 0 || xs[i] != xs[i-1] || ys[i] != ys[i-1]) set_frame(xs[i], ys[i]);
      drive(hs[i], vs[i]);
      repeat (2) @(negedge clk40MHz);
      num_checks++;
      if (rgb_out !== es[i]) begin
        num_errors++;
        $display("FAIL clip_%0d(%0d,%0d): got %h expected %h", i, hs[i], vs[i], rgb_out, es[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] h;
    logic [22:0] exp;
    localparam int N = 60;
    set_frame(12'd100, 12'd200);
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk40MHz);
      if (i >= 2) begin
        exp = exp_q.pop_front();
        num_checks++;
        if ({hcount_out, rgb_out} !== exp) begin
          num_errors++;
          $display("FAIL b2b_%0d: got h %0d rgb %h expected h %0d rgb %h",
                   i - 2, hcount_out, rgb_out, exp[22:12], exp[11:0]);
        end
      end
      if (i < N) begin
        h = 11'(94 + i);
        set_inputs(h, 11'd230);
        exp_q.push_back({h, (h >= 11'd100 && h <= 11'd147) ? SPR : BG});
      end
    end
  endtask

  task automatic test_reset_mid();
    set_frame(12'd100, 12'd200);
    drive(11'd400, 11'd300);
    @(negedge clk40MHz);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk40MHz);
      num_checks++;
      if (rgb_out !== 12'h000 || pixel_addr !== 12'h000 || act_timing() !== 26'd0) begin
        num_errors++;
        $display("FAIL reset_mid_%0d: got rgb %h addr %h timing %h expected all 0",
                 i, rgb_out, pixel_addr, act_timing());
      end
    end
    rst = 1'b0;
    set_inputs(11'd10, 11'd10);
    @(negedge clk40MHz);
    num_checks++;
    if (rgb_out !== 12'h000) begin
      num_errors++;
      $display("FAIL reset_flush: got %h expected 000", rgb_out);
    end
    @(negedge clk40MHz);
    num_checks++;
    if (rgb_out !== SPR || hcount_out !== 11'd10) begin
      num_errors++;
      $display("FAIL reset_resume: got rgb %h h %0d expected %h h 10", rgb_out, hcount_out, SPR);
    end
    drive(11'd120, 11'd210);
    repeat (2) @(negedge clk40MHz);
    num_checks++;
    if (rgb_out !== BG) begin
      num_errors++;
      $display("FAIL reset_pos_zero: got %h expected %h", rgb_out, BG);
    end
    set_frame(12'd100, 12'd200);
    drive(11'd120, 11'd210);
    repeat (2) @(negedge clk40MHz);
    num_checks++;
    if (rgb_out !== SPR) begin
      num_errors++;
      $display("FAIL reset_next_frame: got %h expected %h", rgb_out, SPR);
    end
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_address();
    test_transparency();
    test_frame_start_same_cycle();
    test_tearing();
    test_clipping();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
